// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit: fetch/decode/exec/mem/writeback FSM with ready handshakes,
// memory timeout and sticky illegal trap. Multiply support is enabled by defining CTRL_MUL_EN.
module multicycle_control #(
    parameter int unsigned MUL_CYCLES  = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       instr_ready,
    input  logic       data_ready,
    output logic       instr_mem_read,
    output logic       ir_write,
    output logic       data_mem_read,
    output logic [3:0] data_mem_write,
    output logic       rd_write,
    output logic       pc_write,
    output logic [3:0] aluSel,
    output logic       aluSrc1Sel,
    output logic [2:0] aluSrc2Sel,
    output logic [2:0] wbSel,
    output logic [2:0] pcSel,
    output logic       illegal,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MUL_WAIT, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_LOAD, C_OPIMM, C_JALR, C_STORE, C_BRANCH, C_AUIPC, C_LUI, C_JAL, C_BAD
    } cls_t;

    localparam logic [3:0] ALU_AND = 4'd0,  ALU_OR  = 4'd1,  ALU_ADD  = 4'd2,  ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4,  ALU_XOR = 4'd5,  ALU_SLL  = 4'd6,  ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8,  ALU_SRA = 4'd9,  ALU_NONE = 4'd13, ALU_RS2  = 4'd15;

    localparam bit          TMO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

    if (MUL_CYCLES < 1 || MUL_CYCLES > 16) begin : g_mul_cycles_range
        $error("MUL_CYCLES must be within 1..16");
    end

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    cls_t        cls_q, dec_cls;
    logic [3:0]  alu_sel_q, dec_alu, r_alu, i_alu;
    logic        src1_q, dec_s1;
    logic [2:0]  src2_q, dec_s2, wb_sel_q, dec_wb, pc_sel_q, dec_pc;
    logic [3:0]  be_q, dec_be;
    logic        dec_bad, latch_dec, trap;

`ifdef CTRL_MUL_EN
    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);
    logic [3:0] mul_cnt_q, mul_cnt_d;
    logic       is_mul;
    assign is_mul = (alu_sel_q == 4'd10) || (alu_sel_q == 4'd11) || (alu_sel_q == 4'd12);
`endif

    // Register-register and immediate ALU op selection; NONE marks an illegal encoding.
    always_comb begin
        r_alu = ALU_NONE;
        case (funct7)
            7'b0000000: begin
                case (funct3)
                    3'b000:  r_alu = ALU_ADD;
                    3'b001:  r_alu = ALU_SLL;
                    3'b010:  r_alu = ALU_SLT;
                    3'b011:  r_alu = ALU_SLTU;
                    3'b100:  r_alu = ALU_XOR;
                    3'b101:  r_alu = ALU_SRL;
                    3'b110:  r_alu = ALU_OR;
                    default: r_alu = ALU_AND;
                endcase
            end
            7'b0100000: begin
                if (funct3 == 3'b000) r_alu = ALU_SUB;
                else if (funct3 == 3'b101) r_alu = ALU_SRA;
            end
`ifdef CTRL_MUL_EN
            7'b0000001: begin
                if (funct3 == 3'b000) r_alu = 4'd10;
                else if (funct3 == 3'b001) r_alu = 4'd11;
                else if (funct3 == 3'b011) r_alu = 4'd12;
            end
`endif
            default: r_alu = ALU_NONE;
        endcase

        i_alu = ALU_NONE;
        case (funct3)
            3'b000:  i_alu = ALU_ADD;
            3'b001:  i_alu = (funct7 == 7'b0000000) ? ALU_SLL : ALU_NONE;
            3'b010:  i_alu = ALU_SLT;
            3'b011:  i_alu = ALU_SLTU;
            3'b100:  i_alu = ALU_XOR;
            3'b101:  i_alu = (funct7 == 7'b0000000) ? ALU_SRL :
                             (funct7 == 7'b0100000) ? ALU_SRA : ALU_NONE;
            3'b110:  i_alu = ALU_OR;
            default: i_alu = ALU_AND;
        endcase
    end

    always_comb begin
        dec_cls = C_BAD;
        dec_alu = ALU_NONE;
        dec_s1  = 1'b0;
        dec_s2  = 3'd0;
        dec_wb  = 3'd0;
        dec_pc  = 3'd0;
        dec_be  = 4'b0000;
        case (opcode)
            7'b0110011: begin dec_cls = C_R;     dec_alu = r_alu; end
            7'b0010011: begin dec_cls = C_OPIMM; dec_alu = i_alu; dec_s2 = 3'd2; end
            7'b0000011: begin
                dec_cls = C_LOAD; dec_alu = ALU_ADD; dec_s2 = 3'd2;
                case (funct3)
                    3'b000:  dec_wb = 3'd3;
                    3'b001:  dec_wb = 3'd4;
                    3'b100:  dec_wb = 3'd5;
                    3'b101:  dec_wb = 3'd6;
                    default: dec_wb = 3'd1;
                endcase
            end
            7'b0100011: begin
                dec_cls = C_STORE; dec_alu = ALU_ADD; dec_s2 = 3'd1;
                case (funct3)
                    3'b000:  dec_be = 4'b0001;
                    3'b001:  dec_be = 4'b0011;
                    default: dec_be = 4'b1111;
                endcase
            end
            7'b1100111: begin dec_cls = C_JALR;   dec_alu = ALU_ADD; dec_s2 = 3'd4; dec_wb = 3'd2; dec_pc = 3'd1; end
            7'b1100011: begin dec_cls = C_BRANCH; dec_alu = ALU_ADD; dec_s1 = 1'b1; dec_s2 = 3'd5; dec_pc = 3'd2; end
            7'b0010111: begin dec_cls = C_AUIPC;  dec_alu = ALU_ADD; dec_s1 = 1'b1; dec_s2 = 3'd3; end
            7'b0110111: begin dec_cls = C_LUI;    dec_alu = ALU_RS2; dec_s1 = 1'b1; dec_s2 = 3'd3; end
            7'b1101111: begin dec_cls = C_JAL;    dec_alu = ALU_ADD; dec_s1 = 1'b1; dec_s2 = 3'd6; dec_wb = 3'd2; dec_pc = 3'd1; end
            default:    dec_cls = C_BAD;
        endcase
        dec_bad = (dec_cls == C_BAD) || (dec_alu == ALU_NONE);
    end

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
`ifdef CTRL_MUL_EN
        mul_cnt_d      = mul_cnt_q;
`endif
        latch_dec      = 1'b0;
        instr_mem_read = 1'b0;
        ir_write       = 1'b0;
        data_mem_read  = 1'b0;
        data_mem_write = 4'b0000;
        rd_write       = 1'b0;
        pc_write       = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d    = S_FETCH;
                wait_cnt_d = 16'd0;
            end
            S_FETCH: begin
                instr_mem_read = 1'b1;
                if (instr_ready) begin
                    ir_write   = 1'b1;
                    state_d    = S_DECODE;
                    wait_cnt_d = 16'd0;
                end else if (TMO_EN && wait_cnt_q == TMO_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            S_DECODE: begin
                if (dec_bad) begin
                    state_d = S_TRAP;
                end else begin
                    latch_dec = 1'b1;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                wait_cnt_d = 16'd0;
                if (cls_q == C_LOAD || cls_q == C_STORE) begin
                    state_d = S_MEM;
`ifdef CTRL_MUL_EN
                end else if (is_mul && MUL_CYCLES > 1) begin
                    state_d   = S_MUL_WAIT;
                    mul_cnt_d = 4'd1;
`endif
                end else begin
                    state_d = S_WB;
                end
            end
`ifdef CTRL_MUL_EN
            S_MUL_WAIT: begin
                if (mul_cnt_q == MUL_LAST) state_d = S_WB;
                else mul_cnt_d = mul_cnt_q + 4'd1;
            end
`endif
            S_MEM: begin
                if (cls_q == C_STORE) data_mem_write = be_q;
                else data_mem_read = 1'b1;
                if (data_ready) begin
                    // A store retires here, so the PC advances with the completing access.
                    if (cls_q == C_STORE) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                    wait_cnt_d = 16'd0;
                end else if (TMO_EN && wait_cnt_q == TMO_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            S_WB: begin
                rd_write   = (cls_q != C_BRANCH);
                pc_write   = 1'b1;
                state_d    = S_FETCH;
                wait_cnt_d = 16'd0;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 16'd0;
            cls_q      <= C_R;
            alu_sel_q  <= ALU_NONE;
            src1_q     <= 1'b0;
            src2_q     <= 3'd0;
            wb_sel_q   <= 3'd0;
            pc_sel_q   <= 3'd0;
            be_q       <= 4'b0000;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (latch_dec) begin
                cls_q     <= dec_cls;
                alu_sel_q <= dec_alu;
                src1_q    <= dec_s1;
                src2_q    <= dec_s2;
                wb_sel_q  <= dec_wb;
                pc_sel_q  <= dec_pc;
                be_q      <= dec_be;
            end
        end
    end

`ifdef CTRL_MUL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mul_cnt_q <= 4'd0;
        else     mul_cnt_q <= mul_cnt_d;
    end
`endif

    assign trap       = (state_q == S_TRAP);
    assign illegal    = trap;
    assign state      = state_q;
    assign aluSel     = trap ? ALU_NONE : alu_sel_q;
    assign aluSrc1Sel = trap ? 1'b0 : src1_q;
    assign aluSrc2Sel = trap ? 3'd0 : src2_q;
    assign wbSel      = trap ? 3'd0 : wb_sel_q;
    assign pcSel      = trap ? 3'd0 : pc_sel_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model expands each instruction into an
// expected per-cycle trace that is checked against the DUT every cycle.
module tb_multicycle_control;

    localparam int MULC = 4;
    localparam int TMO  = 15;
`ifdef CTRL_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       instr_ready, data_ready;
    logic       instr_mem_read, ir_write, data_mem_read, rd_write, pc_write, illegal;
    logic [3:0] data_mem_write, aluSel;
    logic       aluSrc1Sel;
    logic [2:0] aluSrc2Sel, wbSel, pcSel, state;

    always #5 clk = ~clk;

    multicycle_control #(.MUL_CYCLES(MULC), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .instr_ready(instr_ready), .data_ready(data_ready),
        .instr_mem_read(instr_mem_read), .ir_write(ir_write), .data_mem_read(data_mem_read),
        .data_mem_write(data_mem_write), .rd_write(rd_write), .pc_write(pc_write),
        .aluSel(aluSel), .aluSrc1Sel(aluSrc1Sel), .aluSrc2Sel(aluSrc2Sel), .wbSel(wbSel),
        .pcSel(pcSel), .illegal(illegal), .state(state)
    );

    typedef struct packed {
        logic       legal, ld, st, br, mul;
        logic [3:0] alu;
        logic       s1;
        logic [2:0] s2, wb, pc;
        logic [3:0] be;
    } info_t;

    typedef struct packed {
        logic       ir, dr;
        logic [2:0] st;
        logic       imr, irw, dmr;
        logic [3:0] dmw;
        logic       rdw, pcw, ill;
        logic       chk_sel, chk_alu;
        logic [3:0] alu;
        logic       s1;
        logic [2:0] s2, wb, pc;
    } cyc_t;

    cyc_t sched[$];
    int   checks = 0;
    int   failures = 0;
    int   obs_rdw, obs_dec, obs_dmr, obs_fetch, obs_alu, obs_wb, obs_last;

    task automatic check(string what, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", what, act, exp);
        end
    endtask

    // Instruction semantics: what the control word of a given instruction must be.
    function automatic info_t model_decode(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
        info_t r;
        int    base[8];
        base    = '{2, 6, 4, 7, 5, 8, 1, 0};   // add sll slt sltu xor srl or and
        r       = '0;
        r.legal = 1'b1;
        r.alu   = 4'd2;
        case (op)
            7'b0110011: begin
                if (f7 == 7'h00) r.alu = 4'(base[f3]);
                else if (f7 == 7'h20 && f3 == 3'd0) r.alu = 4'd3;
                else if (f7 == 7'h20 && f3 == 3'd5) r.alu = 4'd9;
                else if (MUL_EN && f7 == 7'h01 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd3)) begin
                    r.mul = 1'b1;
                    r.alu = (f3 == 3'd3) ? 4'd12 : 4'(10 + f3);
                end else r.legal = 1'b0;
            end
            7'b0010011: begin
                r.s2 = 3'd2;
                if (f3 == 3'd1 && f7 != 7'h00) r.legal = 1'b0;
                else if (f3 == 3'd5 && f7 == 7'h20) r.alu = 4'd9;
                else if (f3 == 3'd5 && f7 != 7'h00) r.legal = 1'b0;
                else r.alu = 4'(base[f3]);
            end
            7'b0000011: begin
                r.ld = 1'b1; r.s2 = 3'd2;
                r.wb = (f3 == 3'd0) ? 3'd3 : (f3 == 3'd1) ? 3'd4 : (f3 == 3'd4) ? 3'd5 :
                       (f3 == 3'd5) ? 3'd6 : 3'd1;
            end
            7'b0100011: begin
                r.st = 1'b1; r.s2 = 3'd1;
                r.be = (f3 == 3'd0) ? 4'h1 : (f3 == 3'd1) ? 4'h3 : 4'hF;
            end
            7'b1100111: begin r.s2 = 3'd4; r.wb = 3'd2; r.pc = 3'd1; end
            7'b1100011: begin r.br = 1'b1; r.s1 = 1'b1; r.s2 = 3'd5; r.pc = 3'd2; end
            7'b0010111: begin r.s1 = 1'b1; r.s2 = 3'd3; end
            7'b0110111: begin r.s1 = 1'b1; r.s2 = 3'd3; r.alu = 4'd15; end
            7'b1101111: begin r.s1 = 1'b1; r.s2 = 3'd6; r.wb = 3'd2; r.pc = 3'd1; end
            default:    r.legal = 1'b0;
        endcase
        if (!r.legal) r.alu = 4'd13;
        return r;
    endfunction

    function automatic cyc_t blank(logic [2:0] st, logic noise);
        cyc_t c;
        c     = '0;
        c.st  = st;
        c.ir  = noise;
        c.dr  = noise;
        c.alu = 4'd13;
        return c;
    endfunction

    function automatic cyc_t with_sel(cyc_t c0, info_t inf);
        cyc_t c;
        c = c0;
        c.chk_sel = 1'b1;
        c.alu = inf.alu; c.s1 = inf.s1; c.s2 = inf.s2; c.wb = inf.wb; c.pc = inf.pc;
        return c;
    endfunction

    // Expand one instruction into its expected cycle trace, starting at the IDLE cycle.
    task automatic build(info_t inf, int fdel, int ddel, bit noise, int tail);
        cyc_t c;
        bit   trapped;
        trapped = 1'b0;
        sched.delete();
        sched.push_back(blank(3'd0, noise));
        for (int i = 0; i < fdel && !(TMO != 0 && i >= TMO); i++) begin
            c = blank(3'd1, noise); c.ir = 1'b0; c.imr = 1'b1;
            sched.push_back(c);
        end
        if (TMO != 0 && fdel >= TMO) trapped = 1'b1;
        else begin
            c = blank(3'd1, noise); c.ir = 1'b1; c.imr = 1'b1; c.irw = 1'b1;
            sched.push_back(c);
            sched.push_back(blank(3'd2, noise));
            if (!inf.legal) trapped = 1'b1;
        end
        if (!trapped) begin
            sched.push_back(with_sel(blank(3'd3, noise), inf));
            if (inf.mul)
                for (int j = 1; j < MULC; j++) sched.push_back(with_sel(blank(3'd4, noise), inf));
            if (inf.ld || inf.st) begin
                for (int j = 0; j < ddel && !(TMO != 0 && j >= TMO); j++) begin
                    c = with_sel(blank(3'd5, noise), inf);
                    c.dr = 1'b0; c.dmr = inf.ld; c.dmw = inf.st ? inf.be : 4'h0;
                    sched.push_back(c);
                end
                if (TMO != 0 && ddel >= TMO) trapped = 1'b1;
                else begin
                    c = with_sel(blank(3'd5, noise), inf);
                    c.dr = 1'b1; c.dmr = inf.ld; c.dmw = inf.st ? inf.be : 4'h0; c.pcw = inf.st;
                    sched.push_back(c);
                end
            end
            if (!trapped && !inf.st) begin
                c = with_sel(blank(3'd6, noise), inf);
                c.rdw = !inf.br; c.pcw = 1'b1;
                sched.push_back(c);
            end
            if (!trapped) begin
                c = blank(3'd1, noise); c.ir = 1'b0; c.imr = 1'b1;
                sched.push_back(c);
            end
        end
        if (trapped)
            for (int j = 0; j < tail; j++) begin
                c = blank(3'd7, noise); c.ill = 1'b1; c.chk_alu = 1'b1;
                sched.push_back(c);
            end
    endtask

    task automatic do_reset(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
        rst = 1'b1; instr_ready = 1'b0; data_ready = 1'b0;
        opcode = op; funct3 = f3; funct7 = f7;
        @(negedge clk);
        check("reset/outputs",
              32'({state, instr_mem_read, ir_write, data_mem_read, data_mem_write, rd_write,
                   pc_write, illegal, aluSel, aluSrc1Sel, aluSrc2Sel, wbSel, pcSel}),
              32'({3'd0, 10'd0, 4'd13, 1'b0, 9'd0}));
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run(string name, int limit);
        int   n, f0;
        cyc_t c;
        f0 = failures;
        n  = (limit > 0 && limit < sched.size()) ? limit : sched.size();
        obs_rdw = -1; obs_dec = -1; obs_dmr = 0; obs_fetch = 0; obs_alu = -1; obs_wb = -1; obs_last = -1;
        for (int k = 0; k < n; k++) begin
            c = sched[k];
            if (k != 0) begin
                @(posedge clk);
                #1;
            end
            instr_ready = c.ir;
            data_ready  = c.dr;
            @(negedge clk);
            check($sformatf("%s/strobes@%0d", name, k),
                  32'({state, instr_mem_read, ir_write, data_mem_read, data_mem_write, rd_write, pc_write, illegal}),
                  32'({c.st, c.imr, c.irw, c.dmr, c.dmw, c.rdw, c.pcw, c.ill}));
            if (c.chk_sel)
                check($sformatf("%s/selects@%0d", name, k),
                      32'({aluSel, aluSrc1Sel, aluSrc2Sel, wbSel, pcSel}),
                      32'({c.alu, c.s1, c.s2, c.wb, c.pc}));
            if (c.chk_alu)
                check($sformatf("%s/aluSel@%0d", name, k), 32'(aluSel), 32'(c.alu));
            if (rd_write && obs_rdw < 0) obs_rdw = k;
            if (state == 3'd2 && obs_dec < 0) obs_dec = k;
            if (data_mem_read) obs_dmr++;
            if (state == 3'd1) obs_fetch++;
            if (state == 3'd3) obs_alu = int'(aluSel);
            if (state == 3'd6) obs_wb = int'(wbSel);
            obs_last = int'(state);
        end
        $display("TXN %-10s op=%b f3=%b f7=%b cycles=%0d new_failures=%0d",
                 name, opcode, funct3, funct7, n, failures - f0);
    endtask

    task automatic instr(string name, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                         int fdel, int ddel, bit noise, int tail);
        do_reset(op, f3, f7);
        build(model_decode(op, f3, f7), fdel, ddel, noise, tail);
        run(name, 0);
    endtask

    initial begin
        rst = 1'b1; instr_ready = 1'b0; data_ready = 1'b0;
        opcode = '0; funct3 = '0; funct7 = '0;

        instr("add", 7'b0110011, 3'b000, 7'h00, 0, 0, 1'b0, 0);
        check("lit/add_alu", 32'(obs_alu), 32'd2);
        check("lit/add_rdw_cycle", 32'(obs_rdw), 32'd4);

        instr("sub_noise", 7'b0110011, 3'b000, 7'h20, 2, 0, 1'b1, 0);

        instr("lbu", 7'b0000011, 3'b100, 7'h00, 0, 3, 1'b0, 0);
        check("lit/lbu_dmr_cycles", 32'(obs_dmr), 32'd4);
        check("lit/lbu_wbsel", 32'(obs_wb), 32'd5);

        instr("sh_noise", 7'b0100011, 3'b001, 7'h00, 1, 2, 1'b1, 0);
        instr("beq", 7'b1100011, 3'b000, 7'h00, 0, 0, 1'b0, 0);
        instr("jal", 7'b1101111, 3'b000, 7'h00, 0, 0, 1'b0, 0);
        instr("jalr", 7'b1100111, 3'b000, 7'h00, 0, 0, 1'b1, 0);
        instr("lui", 7'b0110111, 3'b000, 7'h00, 0, 0, 1'b0, 0);
        instr("auipc", 7'b0010111, 3'b000, 7'h00, 0, 0, 1'b0, 0);
        instr("srai", 7'b0010011, 3'b101, 7'h20, 0, 0, 1'b0, 0);
        instr("lw", 7'b0000011, 3'b010, 7'h00, 0, 0, 1'b0, 0);
        instr("slli_bad", 7'b0010011, 3'b001, 7'h20, 0, 0, 1'b0, 5);

        instr("bad_op", 7'b1111111, 3'b000, 7'h00, 0, 0, 1'b1, 20);
        check("lit/bad_op_state", 32'(obs_last), 32'd7);

        instr("f_timeout", 7'b0110011, 3'b000, 7'h00, 20, 0, 1'b0, 5);
        check("lit/fetch_wait_cycles", 32'(obs_fetch), 32'd15);
        check("lit/fetch_timeout_state", 32'(obs_last), 32'd7);

        instr("m_timeout", 7'b0000011, 3'b010, 7'h00, 0, 20, 1'b0, 5);
        check("lit/mem_timeout_state", 32'(obs_last), 32'd7);

        instr("mulh", 7'b0110011, 3'b001, 7'h01, 0, 0, 1'b0, 5);
`ifdef CTRL_MUL_EN
        check("lit/mulh_alu", 32'(obs_alu), 32'd11);
        check("lit/mulh_dec_to_rdw", 32'(obs_rdw - obs_dec), 32'd5);
`else
        check("lit/mulh_trap_state", 32'(obs_last), 32'd7);
`endif
        instr("mulhsu_bad", 7'b0110011, 3'b010, 7'h01, 0, 0, 1'b0, 5);

        // Store aborted by reset in its second MEM cycle.
        do_reset(7'b0100011, 3'b001, 7'h00);
        build(model_decode(7'b0100011, 3'b001, 7'h00), 0, 10, 1'b0, 0);
        run("st_abort", 6);
        #2 rst = 1'b1;
        #1 check("st_abort/after_rst", 32'({state, data_mem_write, pc_write, rd_write}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle RV32I decoder: FSM sequencing fetch, decode, execute, memory and writeback, with ready handshakes to instruction and data memory.
- Uses the existing control encodings for aluSel/aluSrc*/wbSel/pcSel so the current datapath, ALU and writeback mux are reused unchanged.
- Adds parametrised memory timeout, multi-cycle multiply and a sticky illegal-instruction trap.

Parameters:
- MUL_CYCLES, 4, total EXEC+MUL_WAIT cycles for MUL/MULH/MULHU (legal range 1..16).
- MEM_TIMEOUT, 15, max cycles waiting on instr_ready/data_ready before trap; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- opcode  in  7  instruction bits [6:0], valid from DECODE onward
- funct3  in  3  instruction bits [14:12]
- funct7  in  7  instruction bits [31:25]
- instr_ready  in  1  instruction memory has data this cycle
- data_ready  in  1  data memory access completes this cycle
- instr_mem_read  out  1  instruction fetch request
- ir_write  out  1  latch instruction register
- data_mem_read  out  1  load request
- data_mem_write  out  4  store byte enables
- rd_write  out  1  register-file write strobe
- pc_write  out  1  PC update strobe
- aluSel  out  4  AND0 OR1 ADD2 SUB3 SLT4 XOR5 SLL6 SLTU7 SRL8 SRA9 MUL10 MULH11 MULHU12 NONE13 RS1_14 RS2_15
- aluSrc1Sel  out  1  0 = rs1, 1 = PC
- aluSrc2Sel  out  3  0 rs2, 1 S-imm, 2 I-imm, 3 U-imm, 4 jalr-imm, 5 B-imm, 6 J-imm
- wbSel  out  3  0 alu, 1 lw, 2 pc+4, 3 lb, 4 lh, 5 lbu, 6 lhu
- pcSel  out  3  0 pc+4, 1 jump target, 2 branch
- illegal  out  1  sticky trap flag
- state  out  3  debug state: IDLE0 FETCH1 DECODE2 EXEC3 MUL_WAIT4 MEM5 WB6 TRAP7

Behaviour:
- Reset (async, while rst=1): state=IDLE; every output 0; aluSel=NONE; counters cleared. Reset in any state, mid-access included, aborts the access immediately with no write strobe.
- IDLE: one cycle after rst deasserts, then FETCH.
- FETCH: instr_mem_read=1.
  - When instr_ready=1: ir_write=1 in the same cycle, then DECODE.
  - Wait counter increments each cycle without ready. If it reaches MEM_TIMEOUT: TRAP.
- DECODE: one cycle. Classify by opcode:
  - R 0110011, LOAD 0000011, OP-IMM 0010011, JALR 1100111, STORE 0100011, BRANCH 1100011, AUIPC 0010111, LUI 0110111, JAL 1101111.
  - Latch the class and all select outputs into registers; they hold stable through EXEC..WB.
  - Any other opcode, or an R/OP-IMM funct7 combination that decodes to NONE: TRAP.
  - Select values per class:
    - R: src 0/0, wb 0.
    - LOAD: src 0/2, ADD; wbSel from funct3: 010→1, 000→3, 001→4, 100→5, 101→6, other→1.
    - OP-IMM: src 0/2, wb 0.
    - JALR: src 0/4, ADD, wb 2, pc 1.
    - STORE: src 0/1, ADD; enables from funct3: 010→1111, 000→0001, 001→0011, other→1111.
    - BRANCH: src 1/5, ADD, pc 2.
    - AUIPC: src 1/3, ADD.
    - LUI: src 1/3, RS2.
    - JAL: src 1/6, ADD, wb 2, pc 1.
- EXEC: ALU controls driven, one cycle.
  - LOAD/STORE: go to MEM.
  - MUL class with MUL_CYCLES>1: go to MUL_WAIT.
  - Otherwise: go to WB.
- MUL_WAIT: counter runs from 1 to MUL_CYCLES-1, then WB. No strobes are asserted here.
- MEM: data_mem_read=1 (load) or data_mem_write=enables (store), held until data_ready=1.
  - On data_ready, load: WB.
  - On data_ready, store: pc_write=1 with pcSel=0 in the same cycle, then FETCH.
  - Timeout rules are as in FETCH.
- WB: one cycle, then FETCH.
  - rd_write=1 except for BRANCH.
  - pc_write=1 for every class.
- TRAP: illegal=1; all strobes 0; aluSel=NONE. Exit only via rst.
- data_ready or instr_ready asserted outside its wait state is ignored.
- Strobes are single-cycle except the request/enable levels held in FETCH and MEM.
- Latency: ALU ops take 4 cycles (F, D, E, W) with zero wait. Loads take 5. Stores take 4. MUL takes 3+MUL_CYCLES.

Optional Feature:
- Macro CTRL_MUL_EN.
- Defined: R-type funct7=0000001 with funct3 000/001/011 decodes to MUL/MULH/MULHU and uses MUL_WAIT.
- Undefined: these encodings go to TRAP; the MUL_WAIT state and its counter are not synthesised.

Test Plan:
- Reset released, opcode 0110011 funct3 000 funct7 0, instr_ready=1 always → aluSel=2. rd_write and pc_write pulse in cycle 5 after reset release (IDLE, F, D, E, W); state sequence 0,1,2,3,6,1.
- LOAD funct3 100, data_ready delayed 3 cycles → data_mem_read high exactly 4 cycles, wbSel=5, then one rd_write.
- STORE funct3 001 → data_mem_write=0011 until data_ready; rd_write never asserted; pc_write asserted with data_ready.
- opcode 1111111 → state=7 and illegal=1 after DECODE; both persist 20 cycles; cleared by rst.
- instr_ready held 0 with MEM_TIMEOUT=15 → TRAP after 15 FETCH cycles. Separately, rst pulsed mid-MEM → data_mem_write drops to 0 immediately and state=0.
- CTRL_MUL_EN defined, MUL_CYCLES=4, funct7 0000001 funct3 001 → aluSel=11; cycles from DECODE to rd_write = 5. Rebuilt without the macro, same instruction → TRAP.
